// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared types and constants for the register-file writeback controller.
// Holds the drain FSM state encoding and the address/data widths.
package regfile_wb_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DONE
    } drain_state_e;

endpackage

// File: rtl/regfile_wb_ctrl_scoreboard.sv
// Load scoreboard: per-register pending bits, outstanding-load counter
// and issue hazard detection. Ports: issue fields in, load issue and LSU
// transfer events in; hazard and "counter empty next cycle" out.
module regfile_scoreboard
    import regfile_wb_ctrl_pkg::*;
#(
    parameter int MAX_LOADS = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  iss_valid,
    input  logic [REG_ADDR_W-1:0] iss_rd,
    input  logic                  iss_rd_used,
    input  logic [REG_ADDR_W-1:0] iss_rs1,
    input  logic                  iss_rs1_used,
    input  logic [REG_ADDR_W-1:0] iss_rs2,
    input  logic                  iss_rs2_used,
    input  logic                  iss_is_load,
    input  logic                  ld_issue,
    input  logic                  lsu_xfer,
    input  logic [REG_ADDR_W-1:0] lsu_addr,
    output logic                  hazard,
    output logic                  cnt_zero_next
);

    localparam int CNT_W = $clog2(MAX_LOADS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOADS);

    logic [31:0]      pending_q;
    logic [31:0]      pending_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ret_ok;
    logic             rs1_haz;
    logic             rs2_haz;
    logic             waw_haz;
    logic             full_haz;

    // A return with nothing outstanding is a protocol error and is ignored.
    assign ret_ok = lsu_xfer && (cnt_q != '0);

    always_comb begin
        pending_d = pending_q;
        cnt_d     = cnt_q;
        // Clear before set so a same-cycle issue to that register wins.
        if (ret_ok) begin
            pending_d[lsu_addr] = 1'b0;
        end
        if (ld_issue) begin
            pending_d[iss_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
        if (ld_issue && !ret_ok) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!ld_issue && ret_ok) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    assign cnt_zero_next = (cnt_d == '0);

    // A same-cycle LSU write is forwarded by the register file.
    always_comb begin
        rs1_haz  = iss_rs1_used && (iss_rs1 != '0)
                && pending_q[iss_rs1]
                && !(lsu_xfer && (lsu_addr == iss_rs1));
        rs2_haz  = iss_rs2_used && (iss_rs2 != '0)
                && pending_q[iss_rs2]
                && !(lsu_xfer && (lsu_addr == iss_rs2));
        waw_haz  = iss_rd_used && (iss_rd != '0)
                && pending_q[iss_rd];
        // A same-cycle return frees a slot for the issuing load.
        full_haz = iss_is_load && (cnt_q == CNT_MAX) && !lsu_xfer;
        hazard   = iss_valid
                && (rs1_haz || rs2_haz || waw_haz || full_haz);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    a_no_ret_when_empty : assert property (
        @(posedge clk) disable iff (!rstn)
        !(lsu_xfer && (cnt_q == '0))
    ) else $error("lsu transfer with no outstanding load");

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback controller: merges execute and LSU results onto the register
// file write port, stalls issue on load hazards and runs the drain FSM.
// Ports: ex_* / lsu_* writeback sources, iss_* issue bundle, stall,
// drain_req / drain_done, and the w_* register-file write port.
module regfile_wb_ctrl
    import regfile_wb_ctrl_pkg::*;
#(
    parameter int MAX_LOADS = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  ex_valid,
    input  logic [REG_ADDR_W-1:0] ex_addr,
    input  logic [XLEN-1:0]       ex_data,
    input  logic                  lsu_valid,
    input  logic [REG_ADDR_W-1:0] lsu_addr,
    input  logic [XLEN-1:0]       lsu_data,
    output logic                  lsu_ready,
    input  logic                  iss_valid,
    input  logic [REG_ADDR_W-1:0] iss_rd,
    input  logic                  iss_rd_used,
    input  logic [REG_ADDR_W-1:0] iss_rs1,
    input  logic [REG_ADDR_W-1:0] iss_rs2,
    input  logic                  iss_rs1_used,
    input  logic                  iss_rs2_used,
    input  logic                  iss_is_load,
    output logic                  stall,
    input  logic                  drain_req,
    output logic                  drain_done,
    output logic                  w_enabled,
    output logic [REG_ADDR_W-1:0] w_addr,
    output logic [XLEN-1:0]       w_data
);

    drain_state_e state_q;
    drain_state_e state_d;
    logic         hazard;
    logic         cnt_zero_next;
    logic         lsu_xfer;
    logic         ld_issue;

    // Execute cannot stall, so it always owns the port when valid.
    always_comb begin
        w_enabled = 1'b0;
        w_addr    = '0;
        w_data    = '0;
        lsu_ready = rstn && !ex_valid;
        if (rstn && ex_valid) begin
            w_enabled = 1'b1;
            w_addr    = ex_addr;
            w_data    = ex_data;
        end else if (rstn && lsu_valid) begin
            w_enabled = 1'b1;
            w_addr    = lsu_addr;
            w_data    = lsu_data;
        end
    end

    assign lsu_xfer = lsu_valid && lsu_ready;
    assign stall    = !rstn || (state_q != RUN) || hazard;
    assign ld_issue = iss_valid && !stall && iss_is_load;

    regfile_scoreboard #(
        .MAX_LOADS (MAX_LOADS)
    ) u_sb (
        .clk           (clk),
        .rstn          (rstn),
        .iss_valid     (iss_valid),
        .iss_rd        (iss_rd),
        .iss_rd_used   (iss_rd_used),
        .iss_rs1       (iss_rs1),
        .iss_rs1_used  (iss_rs1_used),
        .iss_rs2       (iss_rs2),
        .iss_rs2_used  (iss_rs2_used),
        .iss_is_load   (iss_is_load),
        .ld_issue      (ld_issue),
        .lsu_xfer      (lsu_xfer),
        .lsu_addr      (lsu_addr),
        .hazard        (hazard),
        .cnt_zero_next (cnt_zero_next)
    );

    always_comb begin
        state_d    = state_q;
        drain_done = 1'b0;
        unique case (state_q)
            RUN: begin
                if (drain_req) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (cnt_zero_next) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                drain_done = rstn;
                state_d    = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

endmodule
